// File: rtl/ultrasonic_echo_emulator_if.sv
// Trigger/echo GPIO bundle between a ranging initiator and the
// emulated ultrasonic sensor that answers it.
interface ultrasonic_echo_emulator_if;
    logic        TRIG;
    logic [17:0] ECHO_CYCLES;
    logic        ECHO;
    logic        BUSY;
    logic        SHORT_TRIG;

    modport master (
        output TRIG,
        output ECHO_CYCLES,
        input  ECHO,
        input  BUSY,
        input  SHORT_TRIG
    );

    modport slave (
        input  TRIG,
        input  ECHO_CYCLES,
        output ECHO,
        output BUSY,
        output SHORT_TRIG
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: validates the trigger width, waits the burst
// latency, drives a programmed echo pulse, then holds off new triggers.
module ultrasonic_echo_emulator #(
    parameter int unsigned MIN_TRIG_CYCLES = 500,
    parameter int unsigned LATENCY_CYCLES  = 10000,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000,
    parameter int unsigned HOLDOFF_CYCLES  = 50000,
    parameter int          CNT_W           = 21
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    ultrasonic_echo_emulator_if.slave    bus
);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_TRIG_CYCLES);
    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(LATENCY_CYCLES);
    localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] echo_w, echo_w_nx;
    logic             sync1, trig_s, trig_d;
    logic [1:0]       vld;
    logic             armed;
    logic             rise;
    logic             short_nx;
    logic             busy_nx;
    logic             echo_q, busy_q, short_q;

    // A trigger needs a low level seen after reset, then a fresh rising edge.
    assign rise = trig_s & ~trig_d & armed;

    // Two-flop synchronizer, edge-detect copy and post-reset arming.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1  <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
            vld    <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1  <= bus.TRIG;
            trig_s <= sync1;
            trig_d <= trig_s;
            vld    <= {vld[0], 1'b1};
            if (vld[1] && !trig_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State, shared counter, captured width and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            echo_w  <= '0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            echo_w  <= echo_w_nx;
            echo_q  <= (state == S_ECHO);
            busy_q  <= busy_nx;
            short_q <= short_nx;
        end
    end

    // Next-state: width check, burst latency, echo width and holdoff.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        echo_w_nx = echo_w;
        short_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nx = S_TRIG_HI;
                    cnt_nx   = ONE_C;
                end
            end
            S_TRIG_HI: begin
                if (!trig_s) begin
                    if (cnt >= MIN_C) begin
                        if (bus.ECHO_CYCLES == 18'd0) begin
                            echo_w_nx = TOUT_C;
                        end else begin
                            echo_w_nx = CNT_W'(bus.ECHO_CYCLES);
                        end
                        cnt_nx   = LAT_C;
                        state_nx = S_BURST;
                    end else begin
                        short_nx = 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_IDLE;
                    end
                end else if (cnt < MIN_C) begin
                    cnt_nx = cnt + ONE_C;
                end
            end
            S_BURST: begin
                if (cnt <= ONE_C) begin
                    state_nx = S_ECHO;
                    cnt_nx   = echo_w;
                end else begin
                    cnt_nx = cnt - ONE_C;
                end
            end
            S_ECHO: begin
                if (cnt <= ONE_C) begin
                    state_nx = S_HOLDOFF;
                    cnt_nx   = HOLD_C;
                end else begin
                    cnt_nx = cnt - ONE_C;
                end
            end
            S_HOLDOFF: begin
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - ONE_C;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // BUSY covers burst, echo and holdoff, aligned with the state register.
    always_comb begin
        busy_nx = (state_nx == S_BURST) ||
                  (state_nx == S_ECHO) ||
                  (state_nx == S_HOLDOFF);
    end

    assign bus.ECHO       = echo_q;
    assign bus.BUSY       = busy_q;
    assign bus.SHORT_TRIG = short_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Bench for ultrasonic_echo_emulator with shortened timing parameters;
// a window-based reference predicts ECHO/BUSY/SHORT_TRIG every cycle.
module tb_ultrasonic_echo_emulator;

    localparam int MIN  = 20;
    localparam int LAT  = 100;
    localparam int TOUT = 3000;
    localparam int HOLD = 400;

    logic clk = 1'b0;
    logic rst_n;

    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .MIN_TRIG_CYCLES (MIN),
        .LATENCY_CYCLES  (LAT),
        .TIMEOUT_CYCLES  (TOUT),
        .HOLDOFF_CYCLES  (HOLD),
        .CNT_W           (21)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int trig_fall_t = 0;
    int echo_rise_t = 0;
    int echo_fall_t = 0;
    int busy_fall_t = 0;
    int echo_rises  = 0;
    int short_cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: each high run of TRIG samples that begins while the
    // responder is idle is judged when it ends; an accepted run opens an
    // echo window and a busy window, a short one a one-cycle pulse.
    initial begin : monitor
        logic        s, ps, pin_prev, e_prev, b_prev, pend_ok;
        logic [17:0] ec;
        int          run_a, pend, busy_s, busy_e;
        int          echo_s, echo_e, short_t, n;
        ps = 1'b1; pin_prev = 1'b0; e_prev = 1'b0; b_prev = 1'b0;
        pend_ok = 1'b0; run_a = -1; pend = -1;
        busy_s = 0; busy_e = 0; echo_s = 0; echo_e = 0; short_t = -1;
        forever begin
            @(posedge clk);
            s  = bus.TRIG;
            ec = bus.ECHO_CYCLES;
            #1;
            cyc++;
            if (!rst_n) begin
                ps = 1'b1; run_a = -1; pend = -1;
                busy_s = 0; busy_e = 0; echo_s = 0; echo_e = 0;
                short_t = -1;
            end else begin
                if (pend == cyc) begin
                    if (pend_ok) begin
                        n      = (ec == 18'd0) ? TOUT : int'(ec);
                        busy_s = cyc;
                        echo_s = cyc + LAT + 1;
                        echo_e = echo_s + n;
                        busy_e = echo_e + HOLD;
                    end else begin
                        short_t = cyc;
                    end
                    pend = -1;
                end
                if (s && !ps) begin
                    run_a = cyc;
                end
                if (!s && ps && run_a >= 0) begin
                    if (run_a + 2 > busy_e) begin
                        pend    = cyc + 2;
                        pend_ok = (cyc - run_a) >= MIN;
                    end
                    run_a = -1;
                end
                ps = s;
            end
            if (!s && pin_prev) trig_fall_t = cyc;
            pin_prev = s;
            if (bus.ECHO && !e_prev) begin
                echo_rise_t = cyc;
                echo_rises++;
            end
            if (!bus.ECHO && e_prev) echo_fall_t = cyc;
            if (!bus.BUSY && b_prev) busy_fall_t = cyc;
            if (bus.SHORT_TRIG) short_cnt++;
            e_prev = bus.ECHO;
            b_prev = bus.BUSY;
            check("echo", int'(bus.ECHO),
                  int'(cyc >= echo_s && cyc < echo_e));
            check("busy", int'(bus.BUSY),
                  int'(cyc >= busy_s && cyc < busy_e));
            check("short_trig", int'(bus.SHORT_TRIG),
                  int'(cyc == short_t));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // TRIG is sampled high by exactly n clock edges.
    task automatic pulse(input int n);
        @(posedge clk);
        #2 bus.TRIG = 1'b1;
        repeat (n) @(posedge clk);
        #2 bus.TRIG = 1'b0;
    endtask

    // Directed scenarios with hand-computed timing expectations.
    initial begin : stim
        int r0, s0;
        rst_n = 1'b0;
        bus.TRIG = 1'b0;
        bus.ECHO_CYCLES = 18'd0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2 bus.TRIG = ~bus.TRIG;
        end
        check("reset_echo", int'(bus.ECHO), 0);
        check("reset_busy", int'(bus.BUSY), 0);
        check("reset_short", int'(bus.SHORT_TRIG), 0);
        @(posedge clk);
        #2 bus.TRIG = 1'b0;
        rst_n = 1'b1;
        idle(10);

        // Nominal: minimum-width trigger, 1000-cycle echo.
        bus.ECHO_CYCLES = 18'd1000;
        r0 = echo_rises;
        pulse(20);
        idle(1600);
        check("nom_latency", echo_rise_t - trig_fall_t, 103);
        check("nom_width", echo_fall_t - echo_rise_t, 1000);
        check("nom_holdoff", busy_fall_t - echo_fall_t, 400);
        check("nom_count", echo_rises - r0, 1);

        // One cycle short, then a good trigger.
        r0 = echo_rises;
        s0 = short_cnt;
        pulse(19);
        idle(10);
        check("short_pulse", short_cnt - s0, 1);
        check("short_no_echo", echo_rises - r0, 0);
        bus.ECHO_CYCLES = 18'd50;
        pulse(30);
        idle(700);
        check("after_short_count", echo_rises - r0, 1);
        check("after_short_width", echo_fall_t - echo_rise_t, 50);

        // No target programmed.
        bus.ECHO_CYCLES = 18'd0;
        pulse(25);
        idle(3600);
        check("timeout_width", echo_fall_t - echo_rise_t, 3000);

        // Activity during echo and holdoff is ignored.
        bus.ECHO_CYCLES = 18'd1000;
        r0 = echo_rises;
        s0 = short_cnt;
        pulse(30);
        idle(300);
        bus.ECHO_CYCLES = 18'd5;
        pulse(30);
        idle(1000);
        pulse(30);
        idle(200);
        check("ignore_width", echo_fall_t - echo_rise_t, 1000);
        check("ignore_count", echo_rises - r0, 1);
        check("ignore_short", short_cnt - s0, 0);

        // Stuck trigger far beyond every counter period.
        bus.ECHO_CYCLES = 18'd200;
        r0 = echo_rises;
        pulse(5000);
        idle(800);
        check("stuck_latency", echo_rise_t - trig_fall_t, 103);
        check("stuck_count", echo_rises - r0, 1);
        check("stuck_width", echo_fall_t - echo_rise_t, 200);

        // Reset while the echo is high clears outputs at once.
        bus.ECHO_CYCLES = 18'd500;
        pulse(25);
        idle(150);
        check("pre_reset_echo", int'(bus.ECHO), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_echo", int'(bus.ECHO), 0);
        check("async_busy", int'(bus.BUSY), 0);
        idle(5);
        #2 rst_n = 1'b1;
        idle(10);
        bus.ECHO_CYCLES = 18'd7;
        r0 = echo_rises;
        pulse(20);
        idle(600);
        check("post_reset_count", echo_rises - r0, 1);
        check("post_reset_width", echo_fall_t - echo_rise_t, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

Bench-side emulator for an HC-SR04-style ultrasonic ranging sensor: the responder end of the trigger/echo GPIO protocol. It watches the trigger line, validates the pulse width, waits a fixed burst latency, then drives an echo pulse whose width in CLOCK_50 cycles is set by switches or by the testbench. It loops back onto the GPIO header so the distance-measurement logic can be exercised on the board without a physical sensor.

## Interface

- MIN_TRIG_CYCLES, 500: minimum accepted trigger high width (10 µs at 50 MHz).
- LATENCY_CYCLES, 10000: trigger-accept to echo-rise delay (emulated 8-cycle 40 kHz burst, 200 µs).
- TIMEOUT_CYCLES, 1900000: echo width when no target is programmed (38 ms).
- HOLDOFF_CYCLES, 50000: recovery after echo falls, during which triggers are ignored.
- CNT_W, 21: width of the internal down/up counters; must hold max(TIMEOUT_CYCLES, LATENCY_CYCLES, HOLDOFF_CYCLES, 2^18-1).

- CLOCK_50  input  1  system clock, 50 MHz; the only clock.
- RESET_N  input  1  asynchronous, active-low reset.
- TRIG  input  1  trigger from the initiator; asynchronous to CLOCK_50.
- ECHO_CYCLES  input  18  programmed echo width in clock cycles; 0 means "no target".
- ECHO  output  1  echo pulse to the initiator, registered.
- BUSY  output  1  high from trigger accept until holdoff ends.
- SHORT_TRIG  output  1  one-cycle pulse when a trigger is rejected as too short.

## Operation

- TRIG passes through a 2-flop synchronizer (trig_s); the FSM uses trig_s and its 1-cycle delayed copy for edge detection.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE: on a rising edge of trig_s, go to TRIG_HI with width counter = 1. A level that is already high on entry to IDLE is not a trigger; a fresh rising edge is required.
- TRIG_HI: increment the width counter each cycle trig_s is high; the counter saturates at MIN_TRIG_CYCLES. On the falling edge of trig_s:
  - width >= MIN_TRIG_CYCLES: capture ECHO_CYCLES into the echo register (0 is replaced by TIMEOUT_CYCLES), load LATENCY_CYCLES, go to BURST.
  - otherwise: pulse SHORT_TRIG for exactly one cycle and return to IDLE.
  - A trigger held high indefinitely keeps the FSM in TRIG_HI.
- BURST: count LATENCY_CYCLES cycles, then go to ECHO.
- ECHO: ECHO high for exactly the captured width, then low; load HOLDOFF_CYCLES and go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE.
- TRIG activity in BURST, ECHO and HOLDOFF is ignored and never raises SHORT_TRIG.
- ECHO_CYCLES is sampled only at accept. Changes afterwards do not affect the pulse in flight.
- Arithmetic is unsigned. The 18-bit capture is zero-extended to CNT_W. Counters never wrap.

## Timing

- Reset values: ECHO=0, BUSY=0, SHORT_TRIG=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). After RESET_N rises, the block needs a new TRIG rising edge.
- Trigger width is measured in trig_s cycles, which equal the number of TRIG pin samples high.
- Pin falling edge to FSM accept is 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- ECHO rises exactly LATENCY_CYCLES + 3 cycles after the first clock edge that samples TRIG low.
- ECHO is high for exactly N cycles, where N is the captured width (TIMEOUT_CYCLES if ECHO_CYCLES was 0).
- BUSY rises in the same cycle the FSM enters BURST. It falls on the cycle the FSM returns to IDLE, which is HOLDOFF_CYCLES after ECHO falls.
- SHORT_TRIG is asserted in the cycle following the trig_s falling edge and lasts exactly 1 cycle.

## Test plan

- Reset: hold RESET_N low with TRIG toggling -> ECHO, BUSY and SHORT_TRIG all stay 0. Assert RESET_N while ECHO is high -> ECHO drops to 0 within the same cycle and the FSM is IDLE.
- Nominal: TRIG high for 500 cycles, ECHO_CYCLES=1000 -> ECHO rises 10003 cycles after TRIG falls, stays high exactly 1000 cycles, and BUSY falls 50000 cycles after ECHO falls.
- Short trigger: TRIG high for 499 cycles -> one-cycle SHORT_TRIG pulse, ECHO stays 0, BUSY stays 0. A following 600-cycle trigger is then accepted normally.
- No target: ECHO_CYCLES=0 with a valid trigger -> ECHO high for exactly 1900000 cycles.
- Ignored activity: during ECHO, change ECHO_CYCLES from 1000 to 5 and pulse TRIG for 600 cycles; repeat the TRIG pulse during HOLDOFF -> width stays 1000, no new echo, no SHORT_TRIG.
- Stuck trigger: TRIG high for 2000000 cycles, then low -> exactly one echo with the standard latency; no counter wrap and no early echo.
